// File: rtl/bsg_counter_pkg.sv
// bsg_counter_pkg: shared state encoding and width helper for the set/enable counter family
package bsg_counter_pkg;

  typedef enum logic {
    e_idle,
    e_run
  } state_e;

  // Bits needed to hold every value 0..max_val; never less than one bit.
  function automatic int width_of_max(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_counter_set_down_en_if.sv
// bsg_counter_set_down_en_if: load/enable/reload controls plus expiry handshake of the down-counter
interface bsg_counter_set_down_en_if #(
  parameter int width_p = 6
);

  logic               set_i;
  logic [width_p-1:0] val_i;
  logic               en_i;
  logic               reload_i;
  logic [width_p-1:0] count_o;
  logic               busy_o;
  logic               expire_v_o;
  logic               expire_yumi_i;
  logic               overrun_o;

  modport master (
    output set_i, val_i, en_i, reload_i, expire_yumi_i,
    input  count_o, busy_o, expire_v_o, overrun_o
  );

  modport slave (
    input  set_i, val_i, en_i, reload_i, expire_yumi_i,
    output count_o, busy_o, expire_v_o, overrun_o
  );

endinterface

// File: rtl/bsg_expire_handshake.sv
// bsg_expire_handshake: holds a pending-expiry flag until acknowledged and flags expiries that
// land on top of an unacknowledged one.
module bsg_expire_handshake (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic event_i,
  input  logic yumi_i,
  input  logic clear_i,
  output logic v_o,
  output logic overrun_o
);

  logic v_q, v_d;
  logic overrun_q, overrun_d;

  // A new expiry keeps the flag up even when the old one is acked in the same cycle.
  always_comb begin
    v_d       = event_i ? 1'b1 : (yumi_i ? 1'b0 : v_q);
    overrun_d = clear_i ? 1'b0 : ((event_i && v_q && !yumi_i) ? 1'b1 : overrun_q);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q       <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      v_q       <= v_d;
      overrun_q <= overrun_d;
    end
  end

  assign v_o       = v_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/bsg_counter_set_down_en.sv
// bsg_counter_set_down_en: loadable down-counter that raises an expiry handshake on reaching zero,
// optionally reloading its start value for periodic operation.
module bsg_counter_set_down_en
  import bsg_counter_pkg::*;
#(
  parameter int max_val_p = 50
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  bsg_counter_set_down_en_if.slave bus
);

  localparam int                  width_lp = width_of_max(max_val_p);
  localparam logic [width_lp-1:0] max_lp   = width_lp'(max_val_p);

  state_e              state_q, state_d;
  logic [width_lp-1:0] count_q, count_d;
  logic [width_lp-1:0] reload_q, reload_d;
  logic [width_lp-1:0] ld;
  logic                expire;
  logic                do_reload;

  // A load in the same cycle suppresses the expiry the decrement would otherwise produce.
  always_comb begin
    ld        = (bus.val_i > max_lp) ? max_lp : bus.val_i;
    expire    = (state_q == e_run) && bus.en_i && !bus.set_i && (count_q == width_lp'(1));
    do_reload = bus.reload_i && (reload_q != '0);
    reload_d  = bus.set_i ? ld : reload_q;
    count_d   = bus.set_i ? ld
              : expire ? (do_reload ? reload_q : '0)
              : ((state_q == e_run) && bus.en_i) ? count_q - width_lp'(1)
              : count_q;
    state_d   = bus.set_i ? ((ld != '0) ? e_run : e_idle)
              : expire ? (do_reload ? e_run : e_idle)
              : state_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_idle;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  bsg_expire_handshake hs (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .event_i  (expire),
    .yumi_i   (bus.expire_yumi_i),
    .clear_i  (bus.set_i),
    .v_o      (bus.expire_v_o),
    .overrun_o(bus.overrun_o)
  );

  assign bus.count_o = count_q;
  assign bus.busy_o  = (state_q == e_run);

endmodule

// File: tb/tb_bsg_counter_set_down_en.sv
// tb_bsg_counter_set_down_en: directed scenarios plus random traffic checked every cycle
// against a behavioural timer model.
module tb_bsg_counter_set_down_en;

  localparam int MAX = 50;
  localparam int W   = bsg_counter_pkg::width_of_max(MAX);

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_cnt, m_start;
  bit m_run, m_v, m_ov;

  bsg_counter_set_down_en_if #(.width_p(W)) bus ();

  bsg_counter_set_down_en #(.max_val_p(MAX)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .bus      (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Timer model: remaining count, remembered start value, pending/overrun flags.
  always @(posedge clk_i or negedge reset_n_i) begin
    int ld;
    bit ev;
    if (!reset_n_i) begin
      m_cnt = 0; m_start = 0; m_run = 0; m_v = 0; m_ov = 0;
    end else begin
      ev = 0;
      if (bus.set_i) begin
        ld = (int'(bus.val_i) > MAX) ? MAX : int'(bus.val_i);
        m_cnt = ld; m_start = ld; m_run = (ld != 0); m_ov = 0;
      end else if (m_run && bus.en_i) begin
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else begin
          ev = 1;
          if (bus.reload_i && m_start != 0) m_cnt = m_start;
          else begin m_cnt = 0; m_run = 0; end
        end
      end
      if (ev) begin
        if (m_v && !bus.expire_yumi_i) m_ov = 1;
        m_v = 1;
      end else if (bus.expire_yumi_i) m_v = 0;
    end
  end

  always @(negedge clk_i) if (chk_en) begin
    chk("model_count", 32'(bus.count_o), 32'(m_cnt));
    chk("model_busy", 32'(bus.busy_o), 32'(m_run));
    chk("model_expire_v", 32'(bus.expire_v_o), 32'(m_v));
    chk("model_overrun", 32'(bus.overrun_o), 32'(m_ov));
  end

  task automatic tick(input bit s, input int v, input bit e, input bit r, input bit y);
    bus.set_i = s;
    bus.val_i = W'(v);
    bus.en_i = e;
    bus.reload_i = r;
    bus.expire_yumi_i = y;
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.set_i = 0; bus.val_i = '0; bus.en_i = 0; bus.reload_i = 0; bus.expire_yumi_i = 0;
    repeat (3) @(posedge clk_i);
    #2 reset_n_i = 1'b1;
    chk_en = 1'b1;
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_v", 32'(bus.expire_v_o), 0);
    chk("rst_ov", 32'(bus.overrun_o), 0);
    // simple countdown from 3
    tick(1, 3, 0, 0, 0);
    chk("t1_load", 32'(bus.count_o), 3);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk("t1_cnt1", 32'(bus.count_o), 1);
    tick(0, 0, 1, 0, 0);
    chk("t1_cnt0", 32'(bus.count_o), 0);
    chk("t1_busy0", 32'(bus.busy_o), 0);
    chk("t1_v", 32'(bus.expire_v_o), 1);
    tick(0, 0, 0, 0, 0);
    chk("t1_v_held", 32'(bus.expire_v_o), 1);
    tick(0, 0, 0, 0, 1);
    chk("t1_v_ack", 32'(bus.expire_v_o), 0);
    // clamp to max and single expiry
    tick(1, 63, 0, 0, 0);
    chk("t2_clamp", 32'(bus.count_o), 50);
    repeat (49) tick(0, 0, 1, 0, 0);
    chk("t2_cnt1", 32'(bus.count_o), 1);
    chk("t2_v0", 32'(bus.expire_v_o), 0);
    tick(0, 0, 1, 0, 0);
    chk("t2_cnt0", 32'(bus.count_o), 0);
    chk("t2_v1", 32'(bus.expire_v_o), 1);
    repeat (3) tick(0, 0, 1, 0, 0);
    chk("t2_idle_cnt", 32'(bus.count_o), 0);
    tick(0, 0, 0, 0, 1);
    // periodic reload without acks
    tick(1, 2, 0, 1, 0);
    tick(0, 0, 1, 1, 0);
    chk("t3_cnt1", 32'(bus.count_o), 1);
    tick(0, 0, 1, 1, 0);
    chk("t3_reload", 32'(bus.count_o), 2);
    chk("t3_v", 32'(bus.expire_v_o), 1);
    chk("t3_ov0", 32'(bus.overrun_o), 0);
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 1, 1, 0);
    chk("t3_ov1", 32'(bus.overrun_o), 1);
    chk("t3_busy", 32'(bus.busy_o), 1);
    // periodic reload with ack at every count of 1
    tick(1, 2, 0, 1, 1);
    chk("t4_v_cleared", 32'(bus.expire_v_o), 0);
    chk("t4_ov_cleared", 32'(bus.overrun_o), 0);
    repeat (3) begin
      tick(0, 0, 1, 1, 0);
      tick(0, 0, 1, 1, 1);
    end
    chk("t4_v", 32'(bus.expire_v_o), 1);
    chk("t4_ov", 32'(bus.overrun_o), 0);
    chk("t4_cnt", 32'(bus.count_o), 2);
    // load beats a would-be expiry and clears overrun
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 1, 1, 0);
    chk("t5_ov_set", 32'(bus.overrun_o), 1);
    tick(0, 0, 0, 0, 1);
    chk("t5_cnt1", 32'(bus.count_o), 1);
    tick(1, 5, 1, 1, 0);
    chk("t5_cnt5", 32'(bus.count_o), 5);
    chk("t5_v0", 32'(bus.expire_v_o), 0);
    chk("t5_ov0", 32'(bus.overrun_o), 0);
    // async reset mid-run with expiry pending
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(1, 5, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk("t6_cnt4", 32'(bus.count_o), 4);
    chk("t6_v1", 32'(bus.expire_v_o), 1);
    #1 reset_n_i = 1'b0;
    #1;
    chk("t6_rst_cnt", 32'(bus.count_o), 0);
    chk("t6_rst_busy", 32'(bus.busy_o), 0);
    chk("t6_rst_v", 32'(bus.expire_v_o), 0);
    #2 reset_n_i = 1'b1;
    repeat (3) tick(0, 0, 1, 1, 0);
    chk("t6_after_cnt", 32'(bus.count_o), 0);
    chk("t6_after_busy", 32'(bus.busy_o), 0);
    // random traffic with occasional async resets
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 15) == 0, $urandom_range(0, 63), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      if (i % 700 == 699) begin
        #1 reset_n_i = 1'b0;
        #1 reset_n_i = 1'b1;
      end
    end
    tick(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
